// File: rtl/nist_result_uart.sv
// Reads N_WORDS pass counts from the NIST result memory and sends them over an 8N1 UART
// as one packet: header byte, data bytes, then the mod-256 sum of the data bytes.
//
// state  | meaning
// S_IDLE | waiting for start, address parked at START_ADDR
// S_HDR  | sending header, first data byte being prefetched
// S_DATA | sending data bytes, next byte prefetched during each frame
// S_CHK  | sending checksum
// S_FIN  | one-cycle done pulse, then back to idle
module nist_result_uart #(
  parameter int          N_WORDS      = 8,
  parameter logic [12:0] START_ADDR   = 13'd0,
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [12:0] mem_raddr,
  input  logic [7:0]  mem_dout,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [7:0] LAST_BYTE = 8'(N_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CHK, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       pref_q, pref_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       byte_idx_q, byte_idx_d;
  logic [12:0]      raddr_q, raddr_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic frame_active;
  logic frame_end;
  logic [7:0] next_idx;

  assign frame_active = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign frame_end    = frame_active && (cnt_q == '0) && (bit_idx_q == 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      pref_q     <= '0;
      csum_q     <= '0;
      byte_idx_q <= '0;
      raddr_q    <= START_ADDR;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      pref_q     <= pref_d;
      csum_q     <= csum_d;
      byte_idx_q <= byte_idx_d;
      raddr_q    <= raddr_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_HDR;
      S_HDR:   if (frame_end) state_d = S_DATA;
      S_DATA:  if (frame_end && (byte_idx_q == LAST_BYTE)) state_d = S_CHK;
      S_CHK:   if (frame_end) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pref_d     = pref_q;
    csum_d     = csum_q;
    byte_idx_d = byte_idx_q;
    raddr_d    = raddr_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    next_idx   = '0;

    if (state_q == S_IDLE) begin
      raddr_d = START_ADDR;
      if (start) begin
        shift_d    = HEADER;
        csum_d     = '0;
        byte_idx_d = '0;
        busy_d     = 1'b1;
        cnt_d      = CNT_LAST;
        bit_idx_d  = '0;
        tx_d       = 1'b0;
      end
    end else if (frame_active) begin
      // Memory data for the address issued at frame start is valid on the frame's second cycle.
      if ((state_q != S_CHK) && (bit_idx_q == 4'd0) && (cnt_q == CNT_CAP))
        pref_d = mem_dout;

      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (bit_idx_q != 4'd9) begin
        cnt_d     = CNT_LAST;
        bit_idx_d = bit_idx_q + 4'd1;
        tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : shift_q[bit_idx_q[2:0]];
      end else begin
        cnt_d     = CNT_LAST;
        bit_idx_d = '0;
        if (state_q == S_CHK) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          raddr_d = START_ADDR;
        end else if ((state_q == S_DATA) && (byte_idx_q == LAST_BYTE)) begin
          tx_d    = 1'b0;
          shift_d = csum_q;
        end else begin
          // Next frame is a data byte; only issue a further read if another byte follows it.
          tx_d       = 1'b0;
          shift_d    = pref_q;
          csum_d     = csum_q + pref_q;
          next_idx   = (state_q == S_HDR) ? 8'd0 : (byte_idx_q + 8'd1);
          byte_idx_d = next_idx;
          if (next_idx != LAST_BYTE) raddr_d = raddr_q + 13'd1;
        end
      end
    end
  end

  assign mem_raddr = raddr_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
